// File: rtl/archie_ide_pkg.sv
// Shared types and constants for the Archie IDE task-file device model.
// Covers FSM states, status bit positions, register indices and write-class command codes.
package archie_ide_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DRQ  = 2'd2
   } ide_state_t;

   localparam int STS_BSY  = 7;
   localparam int STS_DRDY = 6;
   localparam int STS_DSC  = 4;
   localparam int STS_DRQ  = 3;
   localparam int STS_ERR  = 0;

   localparam logic [2:0] REG_DATA     = 3'd0;
   localparam logic [2:0] REG_FEAT     = 3'd1;
   localparam logic [2:0] REG_ERROR    = 3'd1;
   localparam logic [2:0] REG_COUNT    = 3'd2;
   localparam logic [2:0] REG_SECTOR   = 3'd3;
   localparam logic [2:0] REG_CYL_LO   = 3'd4;
   localparam logic [2:0] REG_CYL_HI   = 3'd5;
   localparam logic [2:0] REG_DRV_HEAD = 3'd6;
   localparam logic [2:0] REG_CMD      = 3'd7;

   localparam logic [7:0] WCMD0 = 8'h30;
   localparam logic [7:0] WCMD1 = 8'h31;
   localparam logic [7:0] WCMD2 = 8'hC5;

   function automatic logic is_write_cmd(input logic [7:0] cmd);
      return (cmd == WCMD0) || (cmd == WCMD1) || (cmd == WCMD2);
   endfunction

   // BSY hides every other bit; ERR is only reported once the device is idle.
   function automatic logic [7:0] status_byte(input ide_state_t st, input logic err);
      logic [7:0] s;
      s = 8'h00;
      case (st)
         ST_BUSY: s[STS_BSY] = 1'b1;
         ST_DRQ: begin
            s[STS_DRDY] = 1'b1;
            s[STS_DSC]  = 1'b1;
            s[STS_DRQ]  = 1'b1;
         end
         default: begin
            s[STS_DRDY] = 1'b1;
            s[STS_DSC]  = 1'b1;
            s[STS_ERR]  = err;
         end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ide_sector_buf.sv
// 256x16 dual-port sector buffer; port A follows the CPU pointer, port B the HPS address.
// Reads are registered (one cycle); port A read only updates when a_rd is set.
module ide_sector_buf
   import archie_ide_pkg::*;
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [7:0]  a_addr,
   input  logic        a_we,
   input  logic        a_rd,
   input  logic [15:0] a_din,
   output logic [15:0] a_dout,
   input  logic [7:0]  b_addr,
   input  logic        b_we,
   input  logic [15:0] b_din,
   output logic [15:0] b_dout
);

   logic [15:0] mem [0:255];

   // The two write ports are never active together: A writes only in DRQ, B only in BUSY.
   always_ff @(posedge clk_sys) begin
      if (a_we) mem[a_addr] <= a_din;
      if (b_we) mem[b_addr] <= b_din;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         a_dout <= 16'h0000;
         b_dout <= 16'h0000;
      end else begin
         if (a_rd) a_dout <= mem[a_addr];
         b_dout <= mem[b_addr];
      end
   end

endmodule

// File: rtl/ide_taskfile.sv
// ATA task file, sector buffer and command FSM between the Archie CPU port and the HPS IDE bridge.
// CPU reads answer one cycle after cpu_rd with cpu_ack; the HPS paces each phase with ide_req/ide_ack.
module ide_taskfile
   import archie_ide_pkg::*;
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [2:0]  cpu_addr,
   input  logic [15:0] cpu_din,
   output logic [15:0] cpu_dout,
   output logic        cpu_ack,
   output logic        irq,
   output logic        ide_req,
   input  logic        ide_ack,
   input  logic        ide_err,
   input  logic [2:0]  ide_reg_i_adr,
   output logic [7:0]  ide_reg_i,
   input  logic        ide_reg_we,
   input  logic [2:0]  ide_reg_o_adr,
   input  logic [7:0]  ide_reg_o,
   input  logic [7:0]  ide_data_addr,
   input  logic [15:0] ide_data_o,
   input  logic        ide_data_we,
   input  logic        ide_data_rd,
   output logic [15:0] ide_data_i
);

   ide_state_t  state, state_nxt;
   logic [7:0]  tf [0:7];
   logic [7:0]  ptr;
   logic [8:0]  sec_cnt;
   logic        buf_full;
   logic        err_flag;
   logic        wr_pend;

   logic        req_nxt, irq_set, irq_clr, err_set, cmd_load;
   logic        buf_full_clr, cnt_dec, wr_pend_set, wr_pend_clr;
   logic        data_sel, a_rd, a_we, buf_acc, hps_we, cmd_wr, is_wr, cnt_last;
   logic        rd_sel_buf;
   logic [15:0] rd_reg_q;
   logic [15:0] a_dout;
   logic [7:0]  rd_byte;

   // ide_data_i tracks ide_data_addr every cycle, so the advance strobe carries no extra information.
   logic        unused_data_rd;
   assign unused_data_rd = ide_data_rd;

   assign data_sel = (cpu_addr == REG_DATA);
   assign a_rd     = cpu_rd && data_sel && (state == ST_DRQ);
   assign a_we     = cpu_wr && data_sel && (state == ST_DRQ);
   assign buf_acc  = a_rd || a_we;
   assign hps_we   = ide_data_we && (state == ST_BUSY);
   assign cmd_wr   = cpu_wr && (cpu_addr == REG_CMD);
   assign is_wr    = is_write_cmd(tf[REG_CMD]);
   assign cnt_last = (sec_cnt == 9'd1);

   always_ff @(posedge clk_sys) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      req_nxt      = 1'b0;
      irq_set      = 1'b0;
      irq_clr      = 1'b0;
      err_set      = 1'b0;
      cmd_load     = 1'b0;
      buf_full_clr = 1'b0;
      cnt_dec      = 1'b0;
      wr_pend_set  = 1'b0;
      wr_pend_clr  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cmd_wr) begin
               cmd_load     = 1'b1;
               irq_clr      = 1'b1;
               buf_full_clr = 1'b1;
               req_nxt      = 1'b1;
               state_nxt    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (ide_ack) begin
               if (ide_err) begin
                  err_set   = 1'b1;
                  irq_set   = 1'b1;
                  state_nxt = ST_IDLE;
               end else if (is_wr) begin
                  // wr_pend separates the "ready for data" ack from the "sector stored" ack.
                  if (wr_pend) begin
                     cnt_dec     = 1'b1;
                     wr_pend_clr = 1'b1;
                     if (cnt_last) begin
                        irq_set   = 1'b1;
                        state_nxt = ST_IDLE;
                     end else begin
                        state_nxt = ST_DRQ;
                     end
                  end else begin
                     state_nxt = ST_DRQ;
                  end
               end else if (buf_full || hps_we) begin
                  irq_set   = 1'b1;
                  state_nxt = ST_DRQ;
               end else begin
                  irq_set   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_DRQ: begin
            if (buf_acc && (ptr == 8'hFF)) begin
               if (is_wr) begin
                  wr_pend_set = 1'b1;
                  req_nxt     = 1'b1;
                  state_nxt   = ST_BUSY;
               end else begin
                  cnt_dec = 1'b1;
                  if (cnt_last) begin
                     irq_set   = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     buf_full_clr = 1'b1;
                     req_nxt      = 1'b1;
                     state_nxt    = ST_BUSY;
                  end
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (cpu_rd && (cpu_addr == REG_CMD)) irq_clr = 1'b1;
   end

   always_comb begin
      rd_byte = 8'h00;
      case (cpu_addr)
         REG_ERROR: rd_byte = err_flag ? 8'h04 : 8'h00;
         REG_COUNT, REG_SECTOR, REG_CYL_LO, REG_CYL_HI, REG_DRV_HEAD: rd_byte = tf[cpu_addr];
         REG_CMD: rd_byte = status_byte(state, err_flag);
         default: rd_byte = 8'h00;
      endcase
   end

   // tf[0] is devctl and tf[7] the command, so the HPS read map is a plain index.
   assign ide_reg_i = tf[ide_reg_i_adr];
   assign cpu_dout  = rd_sel_buf ? a_dout : rd_reg_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) tf[i] <= 8'h00;
         ptr        <= 8'h00;
         sec_cnt    <= 9'd0;
         buf_full   <= 1'b0;
         err_flag   <= 1'b0;
         wr_pend    <= 1'b0;
         irq        <= 1'b0;
         ide_req    <= 1'b0;
         cpu_ack    <= 1'b0;
         rd_sel_buf <= 1'b0;
         rd_reg_q   <= 16'h0000;
      end else begin
         ide_req    <= req_nxt;
         cpu_ack    <= cpu_rd;
         rd_sel_buf <= a_rd;
         if (cpu_rd) rd_reg_q <= {8'h00, rd_byte};

         if (cpu_wr && (state == ST_IDLE) && (cpu_addr >= REG_FEAT) && (cpu_addr <= REG_DRV_HEAD))
            tf[cpu_addr] <= cpu_din[7:0];
         if (ide_reg_we && (ide_reg_o_adr >= REG_COUNT) && (ide_reg_o_adr <= REG_DRV_HEAD))
            tf[ide_reg_o_adr] <= ide_reg_o;

         if (cmd_load) begin
            tf[REG_CMD] <= cpu_din[7:0];
            ptr         <= 8'h00;
            sec_cnt     <= (tf[REG_COUNT] == 8'h00) ? 9'd256 : {1'b0, tf[REG_COUNT]};
         end else begin
            if (buf_acc) ptr <= ptr + 8'd1;
            if (cnt_dec) sec_cnt <= sec_cnt - 9'd1;
         end

         if (cmd_load || wr_pend_clr) wr_pend <= 1'b0;
         else if (wr_pend_set)        wr_pend <= 1'b1;

         if (buf_full_clr) buf_full <= 1'b0;
         else if (hps_we)  buf_full <= 1'b1;

         if (err_set)       err_flag <= 1'b1;
         else if (cmd_load) err_flag <= 1'b0;
         else if (ide_reg_we && (ide_reg_o_adr == REG_ERROR))
            err_flag <= (ide_reg_o != 8'h00);

         if (irq_set)      irq <= 1'b1;
         else if (irq_clr) irq <= 1'b0;
      end
   end

   ide_sector_buf u_buf (
      .clk_sys (clk_sys),
      .reset   (reset),
      .a_addr  (ptr),
      .a_we    (a_we),
      .a_rd    (a_rd),
      .a_din   (cpu_din),
      .a_dout  (a_dout),
      .b_addr  (ide_data_addr),
      .b_we    (hps_we),
      .b_din   (ide_data_o),
      .b_dout  (ide_data_i)
   );

endmodule

// File: tb/tb_ide_taskfile.sv
// Bench for ide_taskfile: CPU reads are scoreboarded, HPS-side behaviour checked inline per scenario.
module tb_ide_taskfile;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_rd = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [2:0]  cpu_addr = 3'd0;
   logic [15:0] cpu_din = 16'h0000;
   logic [15:0] cpu_dout;
   logic        cpu_ack;
   logic        irq;
   logic        ide_req;
   logic        ide_ack = 1'b0;
   logic        ide_err = 1'b0;
   logic [2:0]  ide_reg_i_adr = 3'd0;
   logic [7:0]  ide_reg_i;
   logic        ide_reg_we = 1'b0;
   logic [2:0]  ide_reg_o_adr = 3'd0;
   logic [7:0]  ide_reg_o = 8'h00;
   logic [7:0]  ide_data_addr = 8'h00;
   logic [15:0] ide_data_o = 16'h0000;
   logic        ide_data_we = 1'b0;
   logic        ide_data_rd = 1'b0;
   logic [15:0] ide_data_i;

   int          checks = 0;
   int          errors = 0;
   int          req_cnt = 0;
   bit          req_prev = 1'b0;
   logic [15:0] exp_q [$];
   string       tag_q [$];

   ide_taskfile dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .cpu_rd        (cpu_rd),
      .cpu_wr        (cpu_wr),
      .cpu_addr      (cpu_addr),
      .cpu_din       (cpu_din),
      .cpu_dout      (cpu_dout),
      .cpu_ack       (cpu_ack),
      .irq           (irq),
      .ide_req       (ide_req),
      .ide_ack       (ide_ack),
      .ide_err       (ide_err),
      .ide_reg_i_adr (ide_reg_i_adr),
      .ide_reg_i     (ide_reg_i),
      .ide_reg_we    (ide_reg_we),
      .ide_reg_o_adr (ide_reg_o_adr),
      .ide_reg_o     (ide_reg_o),
      .ide_data_addr (ide_data_addr),
      .ide_data_o    (ide_data_o),
      .ide_data_we   (ide_data_we),
      .ide_data_rd   (ide_data_rd),
      .ide_data_i    (ide_data_i)
   );

   always #5 clk_sys = ~clk_sys;

   // Scoreboard and request monitor sample on the falling edge.
   always @(negedge clk_sys) begin
      logic [15:0] e;
      string       t;
      if (cpu_ack) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack got %h expected none", cpu_dout);
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (cpu_dout !== e) begin
               errors++;
               $display("FAIL %s got %h expected %h", t, cpu_dout, e);
            end
         end
      end
      if (ide_req) begin
         req_cnt++;
         checks++;
         if (req_prev) begin
            errors++;
            $display("FAIL req_width got 2+ cycles expected 1");
         end
      end
      req_prev = ide_req;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
      cpu_addr = a;
      cpu_din  = d;
      cpu_wr   = 1'b1;
      tick();
      cpu_wr   = 1'b0;
   endtask

   task automatic cpu_read(input logic [2:0] a, input logic [15:0] exp, input string tag);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      cpu_addr = a;
      cpu_rd   = 1'b1;
      tick();
      cpu_rd   = 1'b0;
   endtask

   task automatic hps_reg_write(input logic [2:0] a, input logic [7:0] d);
      ide_reg_o_adr = a;
      ide_reg_o     = d;
      ide_reg_we    = 1'b1;
      tick();
      ide_reg_we    = 1'b0;
   endtask

   task automatic hps_fill(input logic [15:0] base);
      for (int i = 0; i < 256; i++) begin
         ide_data_addr = 8'(i);
         ide_data_o    = base + 16'(i);
         ide_data_we   = 1'b1;
         tick();
      end
      ide_data_we = 1'b0;
   endtask

   task automatic hps_ack(input logic err);
      ide_err = err;
      ide_ack = 1'b1;
      tick();
      ide_ack = 1'b0;
      ide_err = 1'b0;
   endtask

   function automatic logic [15:0] wpat(input int s, input int i);
      return 16'(32'hA000 + s * 256 + ((i * 7) & 255));
   endfunction

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({cpu_ack, irq, ide_req} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctl got %b expected 000", {cpu_ack, irq, ide_req});
      end
      checks++;
      if ({cpu_dout, ide_data_i} !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got %h expected 0", {cpu_dout, ide_data_i});
      end
      reset = 1'b0;
      tick();
      ide_reg_i_adr = 3'd7;
      #1;
      checks++;
      if (ide_reg_i !== 8'h00) begin
         errors++;
         $display("FAIL reset_cmd_reg got %h expected 00", ide_reg_i);
      end
      cpu_read(3'd7, 16'h0050, "reset_status");
      tick();
      checks++;
      if (irq !== 1'b0 || req_cnt !== 0) begin
         errors++;
         $display("FAIL reset_idle got irq=%b req=%0d expected 0/0", irq, req_cnt);
      end
   endtask

   task automatic test_read_sector();
      int r0;
      cpu_write(3'd2, 16'h0001);
      r0 = req_cnt;
      cpu_write(3'd7, 16'h0020);
      checks++;
      if (ide_req !== 1'b1) begin
         errors++;
         $display("FAIL req_timing got %b expected 1", ide_req);
      end
      tick();
      checks++;
      if (req_cnt !== r0 + 1) begin
         errors++;
         $display("FAIL rd_req_count got %0d expected %0d", req_cnt, r0 + 1);
      end
      ide_reg_i_adr = 3'd7;
      #1;
      checks++;
      if (ide_reg_i !== 8'h20) begin
         errors++;
         $display("FAIL hps_cmd_read got %h expected 20", ide_reg_i);
      end
      cpu_read(3'd7, 16'h0080, "busy_status");
      hps_fill(16'h0000);
      hps_ack(1'b0);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL rd_drq_irq got %b expected 1", irq);
      end
      cpu_read(3'd7, 16'h0058, "rd_drq_status");
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear got %b expected 0", irq);
      end
      for (int i = 0; i < 256; i++) cpu_read(3'd0, 16'(i), "rd_data");
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL rd_done_irq got %b expected 1", irq);
      end
      cpu_read(3'd7, 16'h0050, "rd_done_status");
      checks++;
      if (req_cnt !== r0 + 1) begin
         errors++;
         $display("FAIL rd_extra_req got %0d expected %0d", req_cnt, r0 + 1);
      end
   endtask

   task automatic test_write_sector();
      int r0;
      cpu_write(3'd2, 16'h0002);
      r0 = req_cnt;
      cpu_write(3'd7, 16'h0030);
      tick();
      hps_ack(1'b0);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL wr_ready_irq got %b expected 0", irq);
      end
      cpu_read(3'd7, 16'h0058, "wr_drq_status");
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 256; i++) cpu_write(3'd0, wpat(s, i));
         tick();
         checks++;
         if (req_cnt !== r0 + 2 + s) begin
            errors++;
            $display("FAIL wr_req_count got %0d expected %0d", req_cnt, r0 + 2 + s);
         end
         cpu_read(3'd7, 16'h0080, "wr_busy_status");
         for (int i = 0; i < 256; i++) begin
            ide_data_addr = 8'(i);
            ide_data_rd   = 1'b1;
            tick();
            checks++;
            if (ide_data_i !== wpat(s, i)) begin
               errors++;
               $display("FAIL hps_rd_data[%0d] got %h expected %h", i, ide_data_i, wpat(s, i));
            end
         end
         ide_data_rd = 1'b0;
         hps_ack(1'b0);
         if (s == 0) begin
            cpu_read(3'd7, 16'h0058, "wr_next_status");
         end else begin
            checks++;
            if (irq !== 1'b1) begin
               errors++;
               $display("FAIL wr_done_irq got %b expected 1", irq);
            end
            cpu_read(3'd7, 16'h0050, "wr_done_status");
         end
      end
   endtask

   task automatic test_error();
      int r0;
      r0 = req_cnt;
      cpu_write(3'd7, 16'h0020);
      tick();
      checks++;
      if (req_cnt !== r0 + 1) begin
         errors++;
         $display("FAIL err_req got %0d expected %0d", req_cnt, r0 + 1);
      end
      hps_ack(1'b1);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL err_irq got %b expected 1", irq);
      end
      cpu_read(3'd1, 16'h0004, "err_reg");
      cpu_read(3'd7, 16'h0051, "err_status");
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL err_irq_clear got %b expected 0", irq);
      end
   endtask

   task automatic test_hps_regs();
      int r0;
      cpu_write(3'd7, 16'h0020);
      tick();
      hps_reg_write(3'd2, 8'h05);
      hps_reg_write(3'd6, 8'hA0);
      cpu_write(3'd2, 16'h0077);
      ide_reg_i_adr = 3'd2;
      #1;
      checks++;
      if (ide_reg_i !== 8'h05) begin
         errors++;
         $display("FAIL hps_view_count got %h expected 05", ide_reg_i);
      end
      cpu_read(3'd2, 16'h0005, "cpu_count");
      cpu_read(3'd6, 16'h00A0, "cpu_drv_head");
      cpu_read(3'd1, 16'h0000, "err_cleared");
      hps_ack(1'b0);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL nodata_irq got %b expected 1", irq);
      end
      cpu_read(3'd7, 16'h0050, "nodata_status");
      r0 = req_cnt;
      hps_ack(1'b0);
      tick();
      checks++;
      if (irq !== 1'b0 || req_cnt !== r0) begin
         errors++;
         $display("FAIL idle_ack got irq=%b req=%0d expected 0/%0d", irq, req_cnt, r0);
      end
      cpu_read(3'd7, 16'h0050, "idle_ack_status");
      cpu_write(3'd3, 16'h003C);
      cpu_read(3'd3, 16'h003C, "cpu_sector");
   endtask

   task automatic test_reset_mid();
      int r0;
      cpu_write(3'd2, 16'h0001);
      cpu_write(3'd7, 16'h0020);
      hps_fill(16'h1000);
      hps_ack(1'b0);
      for (int i = 0; i < 100; i++) cpu_read(3'd0, 16'h1000 + 16'(i), "pre_reset_data");
      tick();
      r0 = req_cnt;
      reset = 1'b1;
      repeat (2) tick();
      checks++;
      if ({cpu_ack, irq, ide_req} !== 3'b000 || ide_data_i !== 16'h0000) begin
         errors++;
         $display("FAIL midreset_out got %b/%h expected 000/0000", {cpu_ack, irq, ide_req}, ide_data_i);
      end
      reset = 1'b0;
      repeat (2) tick();
      checks++;
      if (req_cnt !== r0) begin
         errors++;
         $display("FAIL midreset_req got %0d expected %0d", req_cnt, r0);
      end
      cpu_read(3'd7, 16'h0050, "midreset_status");
      cpu_write(3'd2, 16'h0001);
      cpu_write(3'd7, 16'h0020);
      hps_fill(16'h2000);
      hps_ack(1'b0);
      cpu_read(3'd0, 16'h2000, "restart_word0");
      cpu_read(3'd0, 16'h2001, "restart_word1");
   endtask

   initial begin
      test_reset();
      test_read_sector();
      test_write_sector();
      test_error();
      test_hps_regs();
      test_reset_mid();
      repeat (3) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_reads got %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ide_taskfile.md
# ide_taskfile

ATA task-file and sector-buffer device model between the Archie CPU-side IDE interface and the HPS IDE bridge. It holds the host-visible registers and a 256×16 sector buffer, and drives the command/status state machine. It raises `ide_req` towards the HPS side and consumes that side's register writes, data transfers and `ide_ack`/`ide_err` completion. It is the device end of the `ide_*` interface exported by the HPS extension block.

## Interface
- `WCMD0`, 8'h30: write-class command code (CPU→disk).
- `WCMD1`, 8'h31: write-class command code.
- `WCMD2`, 8'hC5: write-class command code.
- `clk_sys` in 1: system clock. Reset `reset`, synchronous, active-high; clock `clk_sys`.
- `reset` in 1: synchronous active-high reset.
- `cpu_rd` in 1: one-cycle CPU read strobe.
- `cpu_wr` in 1: one-cycle CPU write strobe.
- `cpu_addr` in 3: task-file register index.
- `cpu_din` in 16: write data. Only [7:0] is used except for reg 0.
- `cpu_dout` out 16: read data.
- `cpu_ack` out 1: read-data-valid pulse.
- `irq` out 1: interrupt, level.
- `ide_req` out 1: one-cycle request to HPS.
- `ide_ack` in 1: HPS phase end.
- `ide_err` in 1: HPS error flag, sampled with `ide_ack`.
- `ide_reg_i_adr` in 3: HPS register read index.
- `ide_reg_i` out 8: combinational register read data.
- `ide_reg_we` in 1: HPS register write strobe.
- `ide_reg_o_adr` in 3: HPS register write index.
- `ide_reg_o` in 8: HPS register write data.
- `ide_data_addr` in 8: buffer word address, HPS side.
- `ide_data_o` in 16: HPS write data.
- `ide_data_we` in 1: HPS buffer write.
- `ide_data_rd` in 1: HPS buffer read advance.
- `ide_data_i` out 16: registered `buf[ide_data_addr]`.

## Operation
- Registers: features, count, sector, cyl_lo, cyl_hi, drv_head, command, devctl.
  - CPU writes address 1–6 (features, count…drv_head), 7 (command) and 0 (data).
  - CPU reads 1 as error (0x04 when ERR is set, else 0x00), 2–6 as written, 7 as status.
- HPS read map: 0 devctl, 1 features, 2–6 task file, 7 command.
- HPS write map: 1 error, 2–6 task file. Other addresses are ignored. HPS writes are accepted in every state.
- Status byte: {BSY, DRDY=1, 0, DSC=1, DRQ, 0, 0, ERR}.
  - IDLE → 0x50, or 0x51 with ERR.
  - BUSY → 0x80.
  - DRQ → 0x58.
- States:
  - IDLE:
    - CPU write to reg 7 latches command, clears ERR/irq, sets ptr=0 and buf_full=0.
    - Then → BUSY and pulses `ide_req`.
  - BUSY:
    - `ide_data_we` writes `buf[ide_data_addr]` and sets buf_full.
    - On `ide_ack`:
      - with `ide_err`: → IDLE, ERR=1, irq=1.
      - write-class command: → DRQ.
      - buf_full: → DRQ and irq=1.
      - otherwise: → IDLE and irq=1.
  - DRQ:
    - CPU reg 0 access reads or writes `buf[ptr]`, then ptr+1.
    - When ptr wraps 255→0 (read command): decrement sector counter.
      - If the counter reaches 0 → IDLE, irq=1.
      - Otherwise → BUSY, `ide_req`, buf_full=0.
    - When ptr wraps 255→0 (write command): → BUSY and pulse `ide_req`. The HPS drains the buffer, then acks.
    - Write-command ack in BUSY decrements the counter. At 0 → IDLE with irq, else → DRQ.
- Sector counter is 9 bits and is loaded from count on command write; count=0 means 256.
- irq clears on a CPU read of reg 7 or a CPU command write.
- While BSY or DRQ, CPU writes to regs 1–7 are ignored. CPU writes to reg 0 are ignored outside DRQ.
- `ide_ack` in IDLE or DRQ is ignored.

## Timing
- Reset values:
  - `cpu_dout` 0, `cpu_ack` 0, `irq` 0, `ide_req` 0, `ide_data_i` 0.
  - State IDLE, all registers 0, ptr 0, ERR 0, buf_full 0.
- Reset mid-command aborts to IDLE without issuing `ide_req`.
- `cpu_rd` at cycle N → `cpu_dout` and a one-cycle `cpu_ack` at N+1. For reg 0, ptr advances at N+1.
- `ide_req` is asserted exactly one cycle, on the cycle after the triggering event.
- `ide_data_i` is updated one cycle after `ide_data_addr` changes.
- A CPU buffer write and an HPS buffer write in the same cycle cannot occur by state (DRQ vs BUSY).
- Simultaneous `ide_ack` and `ide_data_we`: the write is completed first, and buf_full counts toward the ack decision.

## Structure
- Package `archie_ide_pkg`:
  - state enum (IDLE, BUSY, DRQ);
  - status bit positions;
  - register index constants;
  - write-class command codes.
- Sub-module `ide_sector_buf`: 256×16 true dual-port RAM with registered reads. Port A is the CPU pointer; port B is `ide_data_addr`.

## Test plan
- Reset, then read reg 7 → 0x50, `irq`=0, `ide_req` never pulsed.
- Read sector (count=1):
  - Write reg 7=0x20 → status 0x80 and one `ide_req`.
  - HPS writes 256 words (0x0000..0x00FF), then acks → status 0x58, `irq`=1.
  - 256 CPU reads return 0x0000..0x00FF → status 0x50.
- Write sector (count=2, cmd 0x30):
  - ack → DRQ. CPU writes 256 words → second `ide_req`.
  - HPS reads match the written data; ack → DRQ again. Second sector → IDLE with irq.
- Error: cmd 0x20, then `ide_ack` with `ide_err`=1 → status 0x51, reg 1 = 0x04, `irq`=1; reading reg 7 clears `irq`.
- HPS writes reg 2=0x05 and reg 6=0xA0 during BUSY → CPU reads 0x05 and 0xA0. A CPU write to reg 2 during BUSY is ignored.
- Reset asserted in DRQ after 100 words → status 0x50, and the next command starts at ptr 0.
